vreg_write_arb: RTL

- Controller/arbiter for the vector register bank of 8-bit element registers (each with din/ld/async reset).
- Two requesters share the bank: requester 0 is ALU writeback, requester 1 is memory load.
- Grants one requester a whole-vector burst of VLEN bytes, round-robin between the two.
- Drives the bank's shared 8-bit din bus and one-hot per-element ld strobes; element registers sit directly downstream.

---
 rtl/vproc_pkg.sv | 20 ++
 rtl/vreg_write_arb_rr_arb2.sv | 34 +++
 rtl/vreg_write_arb.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/vproc_pkg.sv
// Shared definitions for the vector register bank write controller:
// arbiter state encoding, element width and flat element-strobe indexing.
package vproc_pkg;

  localparam int DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

  // Flat bit position of element e inside register r of a bank with vlen elements.
  function automatic int unsigned elem_index(input int unsigned r,
                                             input int unsigned e,
                                             input int unsigned vlen);
    return r * vlen + e;
  endfunction

endpackage

// File: rtl/vreg_write_arb_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, with a priority
// pointer that moves to the other requester whenever a tenure ends.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       last_id,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = ~last_id;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/vreg_write_arb.sv
// Whole-vector burst write arbiter for the vector register bank (ALU vs load).
// Optional per-requester completed-burst counters under VREG_ARB_PERF_EN.
module vreg_write_arb
  import vproc_pkg::*;
#(
  parameter  int NREG = 4,
  parameter  int VLEN = 8,
  localparam int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic [AW-1:0]        addr0,
  input  logic [DW-1:0]        data0,
  input  logic                 valid0,
  output logic                 ready0,
  input  logic                 req1,
  input  logic [AW-1:0]        addr1,
  input  logic [DW-1:0]        data1,
  input  logic                 valid1,
  output logic                 ready1,
  output logic                 done0,
  output logic                 done1,
  output logic                 busy,
`ifdef VREG_ARB_PERF_EN
  output logic [15:0]          grants0,
  output logic [15:0]          grants1,
`endif
  output logic [DW-1:0]        din,
  output logic [NREG*VLEN-1:0] ld
);

  localparam int CW = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam int LW = NREG * VLEN;

  arb_state_e    state_q, state_d;
  logic          owner_q, owner_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [DW-1:0] din_q,   din_d;
  logic [LW-1:0] ld_q,    ld_d;

  logic [1:0]    gnt;
  logic          advance;
  logic          req_own, valid_own;
  logic [DW-1:0] data_own;

  rr_arb2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    ({req1, req0}),
    .advance(advance),
    .last_id(owner_q),
    .gnt    (gnt)
  );

  assign req_own   = owner_q ? req1   : req0;
  assign valid_own = owner_q ? valid1 : valid0;
  assign data_own  = owner_q ? data1  : data0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    ld_d    = '0;
    ready0  = 1'b0;
    ready1  = 1'b0;
    done0   = 1'b0;
    done1   = 1'b0;
    busy    = 1'b0;
    advance = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          owner_d = gnt[1];
          addr_d  = gnt[1] ? addr1 : addr0;
          cnt_d   = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        busy   = 1'b1;
        ready0 = ~owner_q;
        ready1 = owner_q;
        if (valid_own) begin
          // Beat lands on the bus one cycle later; out-of-range targets write nothing.
          din_d = data_own;
          if (int'(addr_q) < NREG)
            ld_d = LW'(1) << elem_index(32'(addr_q), 32'(cnt_q), VLEN);
          if (cnt_q == CW'(VLEN - 1)) state_d = ST_DONE;
          else                        cnt_d   = cnt_q + CW'(1);
        end else if (!req_own) begin
          state_d = ST_IDLE;
          advance = 1'b1;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done0   = ~owner_q;
        done1   = owner_q;
        advance = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      din_q   <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      ld_q    <= ld_d;
    end
  end

  assign din = din_q;
  assign ld  = ld_q;

`ifdef VREG_ARB_PERF_EN
  logic [15:0] grants0_q, grants0_d;
  logic [15:0] grants1_q, grants1_d;

  // One increment per DONE cycle; saturate rather than wrap.
  always_comb begin
    grants0_d = grants0_q;
    grants1_d = grants1_q;
    if (state_q == ST_DONE) begin
      if (!owner_q && grants0_q != 16'hFFFF) grants0_d = grants0_q + 16'd1;
      if ( owner_q && grants1_q != 16'hFFFF) grants1_d = grants1_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grants0_q <= '0;
      grants1_q <= '0;
    end else begin
      grants0_q <= grants0_d;
      grants1_q <= grants1_d;
    end
  end

  assign grants0 = grants0_q;
  assign grants1 = grants1_q;
`endif

endmodule
